// File: rtl/pulse_monitor.sv
// pulse_monitor: measures the cycle interval between rising edges of a
// periodic strobe, flags whether it lies inside EXPECTED_PERIOD +/- TOLERANCE,
// and raises a sticky timeout when the strobe goes quiet.
// Optional build macro: PULSE_MONITOR_SYNC_EN adds a 2-flop input synchronizer
// (both flops reset to 1) ahead of edge detection.
module pulse_monitor #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned TIMEOUT_MS      = 2000,
  parameter int unsigned EXPECTED_PERIOD = 50000000,
  parameter int unsigned TOLERANCE       = 1000,
  localparam int unsigned TIMEOUT_COUNT  = (CLOCK_FREQUENCY / 1000) * TIMEOUT_MS,
  localparam int unsigned WIDTH          = $clog2(TIMEOUT_COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [15:0]      edge_count
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] TO_MAX = WIDTH'(TIMEOUT_COUNT);
  localparam logic [31:0]      LO     = EXPECTED_PERIOD - TOLERANCE;
  localparam logic [31:0]      HI     = EXPECTED_PERIOD + TOLERANCE;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] counter, counter_next;
  logic [WIDTH-1:0] period_next;
  logic             period_valid_next;
  logic             locked_next;
  logic             timeout_next;
  logic [15:0]      edge_count_next;
  logic             sample;
  logic             hist;
  logic             rise;
  logic [31:0]      count_ext;

`ifdef PULSE_MONITOR_SYNC_EN
  logic sync_a, sync_b;

  // Two-flop synchronizer; resets high so a held-high input is not an edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= pulse_in;
      sync_b <= sync_a;
    end
  end

  assign sample = sync_b;
`else
  assign sample = pulse_in;
`endif

  assign rise      = sample & ~hist;
  assign count_ext = 32'(counter);

  // State, counter, edge history and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      hist         <= 1'b1;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      edge_count   <= '0;
    end else begin
      state        <= state_next;
      counter      <= counter_next;
      hist         <= sample;
      period       <= period_next;
      period_valid <= period_valid_next;
      locked       <= locked_next;
      timeout      <= timeout_next;
      edge_count   <= edge_count_next;
    end
  end

  // Next-state and next-output logic; an edge takes priority over timeout.
  always_comb begin
    state_next        = state;
    counter_next      = counter;
    period_next       = period;
    period_valid_next = 1'b0;
    locked_next       = locked;
    timeout_next      = timeout;
    edge_count_next   = rise ? edge_count + 16'd1 : edge_count;

    unique case (state)
      IDLE: begin
        counter_next = '0;
        if (rise) begin
          counter_next = ONE;
          state_next   = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_next       = counter;
          period_valid_next = 1'b1;
          counter_next      = ONE;
          timeout_next      = 1'b0;
          locked_next       = (count_ext >= LO) && (count_ext <= HI);
        end else if (counter == TO_MAX) begin
          timeout_next = 1'b1;
          locked_next  = 1'b0;
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter + ONE;
        end
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_monitor.sv
// Scoreboard bench for pulse_monitor: stimulus pushes hand-computed expected
// measurements; a monitor pops and checks them on every period_valid.
module tb_pulse_monitor;

  localparam int unsigned W = 5;

  logic          clock;
  logic          reset;
  logic          pulse_in;
  logic [W-1:0]  period;
  logic          period_valid;
  logic          locked;
  logic          timeout;
  logic [15:0]   edge_count;

  typedef struct {
    int unsigned per;
    logic        lck;
    logic        tmo;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pulse_monitor #(
    .CLOCK_FREQUENCY(1000),
    .TIMEOUT_MS(20),
    .EXPECTED_PERIOD(10),
    .TOLERANCE(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pulse_in(pulse_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout),
    .edge_count(edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_pulse();
    pulse_in = 1'b1;
    step(1);
    pulse_in = 1'b0;
  endtask

  task automatic expect_meas(input int unsigned per, input logic lck, input logic tmo,
                             input int unsigned cnt);
    exp_t e;
    e.per = per;
    e.lck = lck;
    e.tmo = tmo;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    reset    = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // Monitor: every period_valid must match the oldest queued expectation.
  always @(negedge clock) begin
    if (period_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got period=%0d, required no valid", period);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_period", 32'(period), e.per);
        check("sb_locked", 32'(locked), 32'(e.lck));
        check("sb_timeout", 32'(timeout), 32'(e.tmo));
        check("sb_edge_count", 32'(edge_count), e.cnt);
      end
    end
  end

  // Watchdog bound on the whole run.
  initial begin
    repeat (5000) @(posedge clock);
    $display("FAIL watchdog: got no finish, required finish within 5000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pulse_in = 1'b0;
    reset    = 1'b0;

    // Reset values, with pulse_in held high through reset release.
    pulse_in = 1'b1;
    step(2);
    check("rst_period", 32'(period), 0);
    check("rst_valid", 32'(period_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_edge_count", 32'(edge_count), 0);
    reset = 1'b1;
    step(5);
    pulse_in = 1'b0;
    step(3);
    check("held_high_edge_count", 32'(edge_count), 0);
    check("held_high_period", 32'(period), 0);
    check("held_high_locked", 32'(locked), 0);

    // Four pulses, 10 cycles apart.
    do_reset();
    send_pulse(); step(9);
    for (int unsigned k = 2; k <= 4; k++) begin
      expect_meas(10, 1'b1, 1'b0, k);
      send_pulse(); step(9);
    end
    check("p10_edge_count", 32'(edge_count), 4);
    check("p10_locked", 32'(locked), 1);

    // Spacing 12 (out of window) then 9 (inside window edge).
    do_reset();
    send_pulse(); step(11);
    expect_meas(12, 1'b0, 1'b0, 2);
    send_pulse(); step(8);
    expect_meas(9, 1'b1, 1'b0, 3);
    send_pulse(); step(3);

    // Timeout after a 10-cycle period, then recovery.
    do_reset();
    send_pulse(); step(9);
    expect_meas(10, 1'b1, 1'b0, 2);
    send_pulse(); step(19);
    check("to_not_yet", 32'(timeout), 0);
    step(1);
    check("to_timeout", 32'(timeout), 1);
    check("to_locked", 32'(locked), 0);
    check("to_period_kept", 32'(period), 10);
    send_pulse(); step(1);
    check("to_first_edge_keeps", 32'(timeout), 1);
    check("to_first_edge_count", 32'(edge_count), 3);
    step(8);
    expect_meas(10, 1'b1, 1'b0, 4);
    send_pulse(); step(3);
    check("to_cleared", 32'(timeout), 0);

    // Edge arrives exactly when counter reaches the timeout count.
    do_reset();
    send_pulse(); step(19);
    expect_meas(20, 1'b0, 1'b0, 2);
    send_pulse(); step(2);
    check("boundary_timeout", 32'(timeout), 0);

    // Reset mid-measurement (5 cycles in), then pulses every 10.
    step(3);
    reset = 1'b0;
    step(2);
    check("midrst_period", 32'(period), 0);
    check("midrst_edge_count", 32'(edge_count), 0);
    check("midrst_locked", 32'(locked), 0);
    reset = 1'b1;
    step(1);
    send_pulse(); step(9);
    expect_meas(10, 1'b1, 1'b0, 2);
    send_pulse(); step(3);

    step(5);
    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
